// File: rtl/sram_access_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit multi-cycle SRAM as a
// low halfword phase followed by a high halfword phase; freezes the pipeline via ready.
module sram_access_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_WE_N
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [17:0]   sram_addr_q, sram_addr_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;
  logic          we_n_q, we_n_d;

  logic          req, is_wr, is_rd, last;
  logic [31:0]   offs;
  logic [16:0]   word_idx;
  logic          unused_offs_bits;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign is_wr    = MEM_W_EN;
  assign is_rd    = MEM_R_EN & ~MEM_W_EN;
  assign offs     = addr - 32'(ADDR_BASE);
  assign word_idx = offs[18:2];
  assign unused_offs_bits = ^{offs[31:19], offs[1:0]};
  assign last     = (cnt_q == CW'(WAIT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (is_rd) rd_data_d[15:0] = SRAM_DQ_IN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (is_rd) rd_data_d[31:16] = SRAM_DQ_IN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the state being entered.
    case (state_d)
      LOW: begin
        sram_addr_d = {word_idx, 1'b0};
        we_n_d      = ~is_wr;
        dq_oe_d     = is_wr;
        if (is_wr) dq_out_d = wr_data[15:0];
      end
      HIGH: begin
        sram_addr_d = {word_idx, 1'b1};
        we_n_d      = ~is_wr;
        dq_oe_d     = is_wr;
        if (is_wr) dq_out_d = wr_data[31:16];
      end
      default: begin
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign rd_data     = rd_data_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_DQ_OUT = dq_out_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: behavioural SRAM plus a word-level reference
// memory; directed and randomized loads/stores with cycle-exact bus checks.
module tb_sram_access_controller;

  localparam int W    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] addr, wr_data, rd_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT, SRAM_DQ_IN;
  logic        SRAM_DQ_OE, SRAM_WE_N;

  sram_access_controller #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous-read SRAM; every write strobe edge is counted.
  logic [15:0] mem [0:(1<<18)-1];
  int          wr_cnt = 0;
  assign SRAM_DQ_IN = mem[SRAM_ADDR];
  always @(posedge clk) begin
    if (!SRAM_WE_N) begin
      mem[SRAM_ADDR] <= SRAM_DQ_OUT;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] refm [int];
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - 32'(BASE)) >> 2) % (1 << 17));
  endfunction

  // Starts in an IDLE cycle just after an edge; ends in the IDLE cycle after DONE.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    int          idx, wc0;
    logic [31:0] half_exp;
    idx = word_of(a);
    MEM_R_EN = r; MEM_W_EN = w; addr = a; wr_data = d;
    wc0 = wr_cnt;
    if (w) refm[idx] = d;
    else exp_rd = refm[idx];
    #1 chk("ready_c0", 32'(ready), 32'd0);
    for (int c = 1; c <= 2*W+1; c++) begin
      @(posedge clk); #1;
      chk($sformatf("ready_c%0d", c), 32'(ready), 32'(c == 2*W+1));
      if (c <= 2*W) begin
        chk("sram_addr", 32'(SRAM_ADDR), 32'(idx * 2 + (c > W ? 1 : 0)));
        chk("we_n", 32'(SRAM_WE_N), 32'(!w));
        chk("dq_oe", 32'(SRAM_DQ_OE), 32'(w));
        if (w) begin
          half_exp = (c > W) ? (d >> 16) : (d % 32'h10000);
          chk("dq_out", 32'(SRAM_DQ_OUT), half_exp);
        end
      end else begin
        chk("rd_data", rd_data, exp_rd);
        chk("we_n_done", 32'(SRAM_WE_N), 32'd1);
        chk("wr_strobes", 32'(wr_cnt - wc0), w ? 32'(2*W) : 32'd0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    #1 chk("ready_idle", 32'(ready), 32'd1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr(input int idx);
    return 32'(BASE + idx * 4 + int'($urandom_range(0, 3)));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wc;
    reset = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; addr = '0; wr_data = '0;
    exp_rd = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    idle(1);
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("read_deadbeef", rd_data, 32'hDEADBEEF);
    idle(2);

    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b1, rand_addr(i), $urandom);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
    end

    // Both enables set: a write; the last load word must remain on rd_data.
    access(1'b1, 1'b1, rand_addr(5), $urandom);
    idle(1);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) access(1'b0, 1'b1, rand_addr(int'($urandom_range(0, 7))), $urandom);
      else access(1'b1, 1'b0, rand_addr(int'($urandom_range(0, 7))), 32'h0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
    end

    // Address arithmetic corners: below the base wraps to the top word; bit 17+ dropped.
    access(1'b0, 1'b1, 32'd1020, 32'hA5A5_5A5A);
    access(1'b1, 1'b0, 32'd1020, 32'h0);
    access(1'b0, 1'b1, 32'(BASE + 4 * ((1 << 17) + 3)), 32'h1357_9BDF);
    access(1'b1, 1'b0, rand_addr(3), 32'h0);
    chk("wrap_idx3", rd_data, 32'h1357_9BDF);
    idle(1);

    access(1'b1, 1'b0, rand_addr(2), 32'h0);
    access(1'b0, 1'b1, rand_addr(6), 32'hCAFE_F00D);
    access(1'b1, 1'b0, rand_addr(6), 32'h0);
    idle(2);

    // Abort a write in its first HIGH cycle.
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b1; addr = 32'(BASE + 800); wr_data = 32'h0BAD_0BAD;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_in_high", 32'(SRAM_ADDR), 32'(200 * 2 + 1));
    reset = 1'b1; MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = '0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
    chk("abort_rd_data", rd_data, 32'd0);
    wc = wr_cnt;
    idle(4);
    chk("abort_no_writes", 32'(wr_cnt - wc), 32'd0);
    access(1'b1, 1'b0, rand_addr(1), 32'h0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
